gray_bcd_decoder: RTL

GRAY_BCD_DECODER -- requirements
Module: gray_bcd_decoder

---
 rtl/gray_bcd_decoder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/gray_bcd_decoder.sv
// gray_bcd_decoder: bit-serial 4-bit Gray-to-binary decoder with valid/ready
// handshakes on both sides. One bit is resolved per clock, MSB first, so a
// result appears 4 clocks after the input transfer. Results above DIGIT_MAX
// are flagged on out_err but still delivered in full on bcd_out.
// Optional feature: define GRAY_ERR_CNT_EN to build the saturating 8-bit
// counter of errored results on err_cnt; otherwise err_cnt is tied to 0.
module gray_bcd_decoder #(
    parameter int unsigned DIGIT_MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] g_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] bcd_out,
    output logic       out_err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] gray_q, gray_d;
    logic [3:0] bin_q, bin_d;
    logic [1:0] idx_q, idx_d;
    logic       err_q, err_d;
    logic       in_xfer, out_xfer;
    logic       nxt_bit;

    // A new word may enter from IDLE, or from DONE in the same cycle the
    // current result leaves, which gives the 5-cycle back-to-back period.
    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign out_valid = (state_q == StDone);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign bcd_out   = bin_q;
    assign out_err   = err_q;

    // Bit being resolved this cycle: MSB copies gray, the rest chain off the bit above.
    always_comb begin
        if (idx_q == 2'd3) begin
            nxt_bit = gray_q[3];
        end else begin
            nxt_bit = bin_q[idx_q + 2'd1] ^ gray_q[idx_q];
        end
    end

    // Next-state and datapath control for the IDLE/CONV/DONE sequencer.
    always_comb begin
        state_d = state_q;
        gray_d  = gray_q;
        bin_d   = bin_q;
        idx_d   = idx_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_xfer) begin
                    gray_d  = g_in;
                    bin_d   = '0;
                    idx_d   = 2'd3;
                    err_d   = 1'b0;
                    state_d = StConv;
                end
            end
            StConv: begin
                bin_d[idx_q] = nxt_bit;
                idx_d        = idx_q - 2'd1;
                if (idx_q == 2'd0) begin
                    // Full value is known once bit 0 lands; flag it on the way into DONE.
                    err_d   = 32'(bin_d) > DIGIT_MAX;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (in_xfer) begin
                    gray_d  = g_in;
                    bin_d   = '0;
                    idx_d   = 2'd3;
                    err_d   = 1'b0;
                    state_d = StConv;
                end else if (out_xfer) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gray_q  <= '0;
            bin_q   <= '0;
            idx_q   <= 2'd3;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gray_q  <= gray_d;
            bin_q   <= bin_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

`ifdef GRAY_ERR_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Count errored results as they are handed off, sticking at 255.
    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer && err_q && (cnt_q != 8'hff)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
